// File: rtl/pc_gen.sv
// Purpose : IF-stage fetch-PC generator with exception entry/return (EPC/EXL),
//           late redirect with word-alignment flag, and a call/return address stack.
// Latency : PC/EPC/EXL/misalign update one cycle after the request edge; ras_top/ras_valid
//           follow the RAS registers with no input-to-output path.
// Backpressure: stall holds the PC and freezes the RAS; redirect overrides stall;
//           exc/eret take priority over both.
// Ports   : clk, Reset_n (async active-low); NPC, stall, redirect/redirect_pc, exc/exc_pc,
//           eret, ras_push/ras_push_addr, ras_pop in; PC, EPC, EXL, misalign, ras_top,
//           ras_valid out.
module pc_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_4180),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] NPC,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             exc,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic             eret,
    input  logic             ras_push,
    input  logic [WIDTH-1:0] ras_push_addr,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] EPC,
    output logic             EXL,
    output logic             misalign,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_valid
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

    // ---------------- PC / exception state ----------------
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] epc_nxt;
    logic             exl_nxt;
    logic             misalign_nxt;

    always_comb begin
        pc_nxt       = PC;
        epc_nxt      = EPC;
        exl_nxt      = EXL;
        misalign_nxt = 1'b0;
        // exc is only honoured outside the handler; a masked exc falls through
        // so that a simultaneous eret inside the handler still returns.
        if (exc && !EXL) begin
            pc_nxt  = EXC_VECTOR;
            epc_nxt = {exc_pc[WIDTH-1:2], 2'b00};
            exl_nxt = 1'b1;
        end else if (eret && EXL) begin
            pc_nxt  = EPC;
            exl_nxt = 1'b0;
        end else if (redirect) begin
            pc_nxt       = {redirect_pc[WIDTH-1:2], 2'b00};
            misalign_nxt = |redirect_pc[1:0];
        end else if (!stall) begin
            pc_nxt = NPC;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PC       <= RESET_VECTOR;
            EPC      <= '0;
            EXL      <= 1'b0;
            misalign <= 1'b0;
        end else begin
            PC       <= pc_nxt;
            EPC      <= epc_nxt;
            EXL      <= exl_nxt;
            misalign <= misalign_nxt;
        end
    end

    // ---------------- Return-address stack ----------------
    // Circular buffer: ras_ptr always addresses the current top. A push into a
    // full stack advances over the oldest entry, so count saturates.
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;
    logic [CW-1:0]    ras_cnt;
    logic [PW-1:0]    ras_ptr_nxt;
    logic [CW-1:0]    ras_cnt_nxt;
    logic             ras_wr;
    logic [PW-1:0]    ras_wr_idx;
    logic             ras_en;

    always_comb begin
        ras_en      = !stall || redirect;
        ras_ptr_nxt = ras_ptr;
        ras_cnt_nxt = ras_cnt;
        ras_wr      = 1'b0;
        ras_wr_idx  = ras_ptr;
        if (ras_en) begin
            if (ras_push && (!ras_pop || ras_cnt == '0)) begin
                // plain push, or push+pop on an empty stack
                ras_ptr_nxt = ras_ptr + PW'(1);
                ras_wr      = 1'b1;
                ras_wr_idx  = ras_ptr + PW'(1);
                ras_cnt_nxt = (ras_cnt == RAS_FULL) ? ras_cnt : ras_cnt + CW'(1);
            end else if (ras_push && ras_pop) begin
                // return followed by call: replace top in place
                ras_wr     = 1'b1;
                ras_wr_idx = ras_ptr;
            end else if (ras_pop && ras_cnt != '0) begin
                ras_ptr_nxt = ras_ptr - PW'(1);
                ras_cnt_nxt = ras_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            ras_ptr <= ras_ptr_nxt;
            ras_cnt <= ras_cnt_nxt;
            if (ras_wr) begin
                ras_mem[ras_wr_idx] <= ras_push_addr;
            end
        end
    end

    assign ras_valid = (ras_cnt != '0);
    assign ras_top   = ras_valid ? ras_mem[ras_ptr] : '0;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        exc;
        logic [31:0] epc_in;
        logic        eret;
        logic [31:0] npc;
        logic        push;
        logic [31:0] pa;
        logic        pop;
    } in_t;

    typedef struct {
        in_t         i;
        logic [31:0] e_pc;
        logic [31:0] e_epc;
        logic        e_exl;
        logic        e_mis;
        logic [31:0] e_top;
        logic        e_vld;
    } vec_t;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic [31:0] NPC = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        exc = 1'b0;
    logic [31:0] exc_pc = '0;
    logic        eret = 1'b0;
    logic        ras_push = 1'b0;
    logic [31:0] ras_push_addr = '0;
    logic        ras_pop = 1'b0;
    logic [31:0] PC, EPC, ras_top;
    logic        EXL, misalign, ras_valid;

    int checks = 0;
    int failures = 0;

    pc_gen dut (
        .clk(clk), .Reset_n(Reset_n), .NPC(NPC), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .exc(exc), .exc_pc(exc_pc),
        .eret(eret), .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
        .PC(PC), .EPC(EPC), .EXL(EXL), .misalign(misalign),
        .ras_top(ras_top), .ras_valid(ras_valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // RAS modelled as a bounded stack: newest at the back, oldest dropped at the front.
    localparam int DEPTH = 4;
    logic [31:0] m_pc, m_epc;
    logic        m_exl, m_mis;
    logic [31:0] m_ras[$];

    function automatic void model_reset();
        m_pc  = 32'h0000_3000;
        m_epc = '0;
        m_exl = 1'b0;
        m_mis = 1'b0;
        m_ras.delete();
    endfunction

    function automatic void model_step(in_t i);
        if (!i.stall || i.redirect) begin
            if (i.push && i.pop && m_ras.size() > 0) begin
                m_ras[m_ras.size()-1] = i.pa;
            end else if (i.push) begin
                m_ras.push_back(i.pa);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (i.pop && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
        m_mis = 1'b0;
        if (i.exc && !m_exl) begin
            m_pc  = 32'h0000_4180;
            m_epc = i.epc_in & ~32'h3;
            m_exl = 1'b1;
        end else if (i.eret && m_exl) begin
            m_pc  = m_epc;
            m_exl = 1'b0;
        end else if (i.redirect) begin
            m_pc  = i.rpc & ~32'h3;
            m_mis = (i.rpc % 4) != 0;
        end else if (!i.stall) begin
            m_pc = i.npc;
        end
    endfunction

    function automatic logic [31:0] m_top();
        return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t i);
        stall = i.stall; redirect = i.redirect; redirect_pc = i.rpc;
        exc = i.exc; exc_pc = i.epc_in; eret = i.eret; NPC = i.npc;
        ras_push = i.push; ras_push_addr = i.pa; ras_pop = i.pop;
    endtask

    // apply one cycle of inputs, advance the model, sample #1 after the edge
    task automatic step(input in_t i);
        drive(i);
        model_step(i);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".PC"}, PC, m_pc);
        chk({tag, ".EPC"}, EPC, m_epc);
        chk({tag, ".EXL"}, {31'b0, EXL}, {31'b0, m_exl});
        chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, m_mis});
        chk({tag, ".ras_top"}, ras_top, m_top());
        chk({tag, ".ras_valid"}, {31'b0, ras_valid}, {31'b0, m_ras.size() > 0});
    endtask

    function automatic in_t idle(input logic [31:0] npc);
        in_t r;
        r = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, npc, 1'b0, 32'h0, 1'b0};
        return r;
    endfunction

    vec_t vt[28];
    in_t  ri;

    initial begin
        //                stall rd  rpc          exc epc_in       eret npc          push pa           pop   pc           epc          exl  mis  top          vld
        vt[0]  = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3004,1'b0,32'h0,  1'b0}, 32'h3004,32'h0,   1'b0,1'b0,32'h0,  1'b0};
        vt[1]  = '{'{1'b1,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3008,1'b0,32'h0,  1'b0}, 32'h3004,32'h0,   1'b0,1'b0,32'h0,  1'b0};
        vt[2]  = '{'{1'b1,1'b1,32'h3402,   1'b0,32'h0,      1'b0,32'h3008,1'b0,32'h0,  1'b0}, 32'h3400,32'h0,   1'b0,1'b1,32'h0,  1'b0};
        vt[3]  = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3404,1'b0,32'h0,  1'b0}, 32'h3404,32'h0,   1'b0,1'b0,32'h0,  1'b0};
        vt[4]  = '{'{1'b0,1'b0,32'h0,      1'b1,32'h3010,   1'b0,32'h3408,1'b0,32'h0,  1'b0}, 32'h4180,32'h3010,1'b1,1'b0,32'h0,  1'b0};
        vt[5]  = '{'{1'b0,1'b0,32'h0,      1'b1,32'h3020,   1'b0,32'h4184,1'b0,32'h0,  1'b0}, 32'h4184,32'h3010,1'b1,1'b0,32'h0,  1'b0};
        vt[6]  = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b1,32'h4188,1'b0,32'h0,  1'b0}, 32'h3010,32'h3010,1'b0,1'b0,32'h0,  1'b0};
        vt[7]  = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b1,32'h3014,1'b0,32'h0,  1'b0}, 32'h3014,32'h3010,1'b0,1'b0,32'h0,  1'b0};
        vt[8]  = '{'{1'b0,1'b0,32'h0,      1'b1,32'h3018,   1'b0,32'h3018,1'b0,32'h0,  1'b0}, 32'h4180,32'h3018,1'b1,1'b0,32'h0,  1'b0};
        vt[9]  = '{'{1'b0,1'b0,32'h0,      1'b1,32'h3030,   1'b1,32'h9999,1'b0,32'h0,  1'b0}, 32'h3018,32'h3018,1'b0,1'b0,32'h0,  1'b0};
        vt[10] = '{'{1'b0,1'b1,32'h3500,   1'b1,32'h3023,   1'b0,32'h9999,1'b0,32'h0,  1'b0}, 32'h4180,32'h3020,1'b1,1'b0,32'h0,  1'b0};
        vt[11] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b1,32'h3024,1'b0,32'h0,  1'b0}, 32'h3020,32'h3020,1'b0,1'b0,32'h0,  1'b0};
        vt[12] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3024,1'b1,32'h100,1'b0}, 32'h3024,32'h3020,1'b0,1'b0,32'h100,1'b1};
        vt[13] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3028,1'b1,32'h104,1'b0}, 32'h3028,32'h3020,1'b0,1'b0,32'h104,1'b1};
        vt[14] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h302C,1'b1,32'h108,1'b0}, 32'h302C,32'h3020,1'b0,1'b0,32'h108,1'b1};
        vt[15] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3030,1'b1,32'h10C,1'b0}, 32'h3030,32'h3020,1'b0,1'b0,32'h10C,1'b1};
        vt[16] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3034,1'b1,32'h110,1'b0}, 32'h3034,32'h3020,1'b0,1'b0,32'h110,1'b1};
        vt[17] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3038,1'b0,32'h0,  1'b1}, 32'h3038,32'h3020,1'b0,1'b0,32'h10C,1'b1};
        vt[18] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h303C,1'b0,32'h0,  1'b1}, 32'h303C,32'h3020,1'b0,1'b0,32'h108,1'b1};
        vt[19] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3040,1'b0,32'h0,  1'b1}, 32'h3040,32'h3020,1'b0,1'b0,32'h104,1'b1};
        vt[20] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3044,1'b0,32'h0,  1'b1}, 32'h3044,32'h3020,1'b0,1'b0,32'h0,  1'b0};
        vt[21] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3048,1'b0,32'h0,  1'b1}, 32'h3048,32'h3020,1'b0,1'b0,32'h0,  1'b0};
        vt[22] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h304C,1'b1,32'h200,1'b1}, 32'h304C,32'h3020,1'b0,1'b0,32'h200,1'b1};
        vt[23] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3050,1'b1,32'h300,1'b1}, 32'h3050,32'h3020,1'b0,1'b0,32'h300,1'b1};
        vt[24] = '{'{1'b1,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3054,1'b1,32'h400,1'b0}, 32'h3050,32'h3020,1'b0,1'b0,32'h300,1'b1};
        vt[25] = '{'{1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3058,1'b0,32'h0,  1'b1}, 32'h3058,32'h3020,1'b0,1'b0,32'h0,  1'b0};
        vt[26] = '{'{1'b1,1'b1,32'h3600,   1'b0,32'h0,      1'b0,32'h305C,1'b1,32'h500,1'b0}, 32'h3600,32'h3020,1'b0,1'b0,32'h500,1'b1};
        vt[27] = '{'{1'b1,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h3604,1'b0,32'h0,  1'b1}, 32'h3600,32'h3020,1'b0,1'b0,32'h500,1'b1};

        // ---- power-on reset, asserted between edges ----
        #2 Reset_n = 1'b0;
        #1;
        chk("reset.PC", PC, 32'h3000);
        chk("reset.EPC", EPC, 32'h0);
        chk("reset.EXL", {31'b0, EXL}, 32'h0);
        chk("reset.misalign", {31'b0, misalign}, 32'h0);
        chk("reset.ras_valid", {31'b0, ras_valid}, 32'h0);
        chk("reset.ras_top", ras_top, 32'h0);
        model_reset();
        @(negedge clk);
        Reset_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- directed vector table ----
        for (int k = 0; k < 28; k++) begin
            string t;
            t = $sformatf("vec%0d", k);
            step(vt[k].i);
            chk({t, ".PC"}, PC, vt[k].e_pc);
            chk({t, ".EPC"}, EPC, vt[k].e_epc);
            chk({t, ".EXL"}, {31'b0, EXL}, {31'b0, vt[k].e_exl});
            chk({t, ".misalign"}, {31'b0, misalign}, {31'b0, vt[k].e_mis});
            chk({t, ".ras_top"}, ras_top, vt[k].e_top);
            chk({t, ".ras_valid"}, {31'b0, ras_valid}, {31'b0, vt[k].e_vld});
        end

        // misalign must drop back after exactly one cycle
        step(idle(32'h3608));
        chk("mis_pulse.set", {31'b0, misalign}, 32'h0);
        ri = idle(32'h0);
        ri.redirect = 1'b1; ri.rpc = 32'h3701;
        step(ri);
        chk("mis_pulse.on", {31'b0, misalign}, 32'h1);
        step(idle(32'h370C));
        chk("mis_pulse.off", {31'b0, misalign}, 32'h0);
        chk("mis_pulse.pc", PC, 32'h370C);

        // ---- randomized run against the model ----
        for (int n = 0; n < 3000; n++) begin
            ri.stall    = ($urandom_range(0, 3) == 0);
            ri.redirect = ($urandom_range(0, 5) == 0);
            ri.rpc      = $urandom;
            ri.exc      = ($urandom_range(0, 7) == 0);
            ri.epc_in   = $urandom;
            ri.eret     = ($urandom_range(0, 5) == 0);
            ri.npc      = $urandom;
            ri.push     = ($urandom_range(0, 2) == 0);
            ri.pa       = $urandom;
            ri.pop      = ($urandom_range(0, 2) == 0);
            step(ri);
            chk_model($sformatf("rnd%0d", n));
        end

        // ---- reset mid-cycle with requests pending ----
        ri = idle(32'h5000);
        ri.exc = 1'b1; ri.epc_in = 32'h7770; ri.push = 1'b1; ri.pa = 32'h888; ri.redirect = 1'b1;
        drive(ri);
        #2 Reset_n = 1'b0;
        #1;
        chk("midreset.PC", PC, 32'h3000);
        chk("midreset.EXL", {31'b0, EXL}, 32'h0);
        chk("midreset.ras_valid", {31'b0, ras_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("midreset.held.PC", PC, 32'h3000);
        chk("midreset.held.EPC", EPC, 32'h0);
        model_reset();
        drive(idle(32'h3004));
        @(negedge clk);
        Reset_n = 1'b1;
        step(idle(32'h3004));
        chk_model("post_reset");
        chk("post_reset.PC", PC, 32'h3004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
